// File: rtl/seven_seg_scan_driver.sv
// seven_seg_scan_driver
//   Drives a 4-digit, common-anode, time-multiplexed seven-segment display.
//   A free-running converter (IDLE -> LOAD -> SHIFT x16 -> DONE -> LOAD ...)
//   samples the input word, optionally converts it to BCD with a sequential
//   double-dabble engine, and commits the result to the display registers
//   atomically. A refresh counter scans one digit every REFRESH_DIV cycles.
//
// Ports:
//   clk           system clock
//   rst           synchronous reset, active-high
//   value_in      16-bit word to display
//   decimal_point DP mask, bit i belongs to digit i (bit3 = leftmost)
//   bcd_mode      1 = show as decimal, 0 = show as 4 hex digits
//   segments      {g,f,e,d,c,b,a}, active-low
//   dp            decimal-point segment, active-low
//   anode         digit enables, active-low, anode[i] drives digit i
//   overflow      last committed BCD value exceeded 9999 (shown as 9999)
//   conv_busy     converter is in LOAD or SHIFT
module seven_seg_scan_driver #(
    parameter int unsigned REFRESH_DIV   = 100000,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] value_in,
    input  logic [3:0]  decimal_point,
    input  logic        bcd_mode,
    output logic [6:0]  segments,
    output logic        dp,
    output logic [3:0]  anode,
    output logic        overflow,
    output logic        conv_busy
);

    localparam int unsigned CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } conv_state_t;

    conv_state_t state;

    // Converter working registers
    logic [19:0] bcd_scr;
    logic [15:0] bin_scr;
    logic [4:0]  shift_cnt;
    logic [15:0] cap_value;
    logic [3:0]  cap_dp;
    logic        cap_mode;
    logic [19:0] bcd_adj;

    // Committed display registers
    logic [15:0] digits_reg;
    logic [3:0]  dp_reg;
    logic        mode_reg;

    // Scan registers
    logic [CW-1:0] refresh_cnt;
    logic [1:0]    idx;
    logic [3:0]    blank_vec;
    logic [3:0]    cur_digit;

    function automatic logic [6:0] hex_font(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
    always_comb begin
        bcd_adj = bcd_scr;
        for (int unsigned n = 0; n < 5; n++) begin
            if (bcd_scr[4*n +: 4] >= 4'd5) begin
                bcd_adj[4*n +: 4] = bcd_scr[4*n +: 4] + 4'd3;
            end
        end
    end

    // Converter FSM; conv_busy is registered from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            conv_busy  <= 1'b0;
            bcd_scr    <= '0;
            bin_scr    <= '0;
            shift_cnt  <= '0;
            cap_value  <= '0;
            cap_dp     <= '0;
            cap_mode   <= 1'b0;
            digits_reg <= '0;
            dp_reg     <= '0;
            mode_reg   <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    state     <= S_LOAD;
                    conv_busy <= 1'b1;
                end
                S_LOAD: begin
                    cap_value <= value_in;
                    cap_dp    <= decimal_point;
                    cap_mode  <= bcd_mode;
                    bin_scr   <= value_in;
                    bcd_scr   <= '0;
                    shift_cnt <= 5'd16;
                    state     <= S_SHIFT;
                    conv_busy <= 1'b1;
                end
                S_SHIFT: begin
                    {bcd_scr, bin_scr} <= {bcd_adj, bin_scr} << 1;
                    shift_cnt          <= shift_cnt - 5'd1;
                    if (shift_cnt == 5'd1) begin
                        state     <= S_DONE;
                        conv_busy <= 1'b0;
                    end else begin
                        conv_busy <= 1'b1;
                    end
                end
                default: begin
                    // All display registers change in this single cycle
                    if (!cap_mode) begin
                        digits_reg <= cap_value;
                        overflow   <= 1'b0;
                    end else if (cap_value > 16'd9999) begin
                        digits_reg <= 16'h9999;
                        overflow   <= 1'b1;
                    end else begin
                        digits_reg <= bcd_scr[15:0];
                        overflow   <= 1'b0;
                    end
                    dp_reg    <= cap_dp;
                    mode_reg  <= cap_mode;
                    state     <= S_LOAD;
                    conv_busy <= 1'b1;
                end
            endcase
        end
    end

    // Leading-zero blanking: a digit blanks only if it and every digit to
    // its left are zero with no decimal point lit; digit 0 always shows.
    always_comb begin
        logic z3, z2, z1;
        z3 = (digits_reg[15:12] == 4'd0) && !dp_reg[3];
        z2 = z3 && (digits_reg[11:8] == 4'd0) && !dp_reg[2];
        z1 = z2 && (digits_reg[7:4] == 4'd0) && !dp_reg[1];
        blank_vec = '0;
        if (BLANK_LEADING && mode_reg) begin
            blank_vec = {z3, z2, z1, 1'b0};
        end
        cur_digit = digits_reg[4*idx +: 4];
    end

    // Refresh counter, digit index and registered pin outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt <= '0;
            idx         <= '0;
            anode       <= 4'b1111;
            segments    <= 7'h7F;
            dp          <= 1'b1;
        end else begin
            if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
                refresh_cnt <= '0;
                idx         <= idx + 2'd1;
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
            anode    <= ~(4'b0001 << idx);
            segments <= blank_vec[idx] ? 7'h7F : hex_font(cur_digit);
            dp       <= ~dp_reg[idx];
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
module tb_seven_seg_scan_driver;

    localparam int RD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] value_in = '0;
    logic [3:0]  decimal_point = '0;
    logic        bcd_mode = 1'b0;
    logic [6:0]  segments;
    logic        dp;
    logic [3:0]  anode;
    logic        overflow;
    logic        conv_busy;

    int total = 0;
    int bad   = 0;

    seven_seg_scan_driver #(
        .REFRESH_DIV   (RD),
        .BLANK_LEADING (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .value_in      (value_in),
        .decimal_point (decimal_point),
        .bcd_mode      (bcd_mode),
        .segments      (segments),
        .dp            (dp),
        .anode         (anode),
        .overflow      (overflow),
        .conv_busy     (conv_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] font(input int d);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[d];
    endfunction

    // Expected segments of digit i for a committed (value, mode, dp mask)
    function automatic logic [6:0] model_seg(input int v, input bit mode,
                                             input logic [3:0] dpm, input int i);
        int vv = v;
        int p = 1;
        int d;
        if (mode && vv > 9999) vv = 9999;
        for (int k = 0; k < i; k++) p = p * 10;
        d = mode ? (vv / p) % 10 : (vv >> (4 * i)) & 15;
        if (mode && i >= 1 && vv < p && (int'(dpm) >> i) == 0) return 7'h7F;
        return font(d);
    endfunction

    function automatic int anode_idx(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic apply(input int v, input bit mode, input logic [3:0] dpm);
        value_in      = v[15:0];
        bcd_mode      = mode;
        decimal_point = dpm;
    endtask

    // Returns with the converter just entered LOAD (seen at a falling edge)
    task automatic wait_load(output bit ok);
        logic prev;
        ok = 1'b0;
        @(negedge clk);
        prev = conv_busy;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            if (conv_busy && !prev) ok = 1'b1;
            prev = conv_busy;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL wait_load: conv_busy rise not seen within 60 cycles");
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        apply(0, 1'b0, 4'b0000);
        repeat (3) @(negedge clk);
        total++;
        if ({anode, segments, dp, overflow, conv_busy} !== {4'b1111, 7'h7F, 1'b1, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs: got anode=%b seg=%h dp=%b ovf=%b busy=%b want 1111 7f 1 0 0",
                     anode, segments, dp, overflow, conv_busy);
        end
        rst = 1'b0;
    endtask

    // Steady-state display check with scan order and dwell time
    task automatic test_display(input string name, input int v, input bit mode,
                                input logic [3:0] dpm);
        int prev_i = -1;
        int run = 0;
        bit seen = 1'b0;
        int i;
        apply(v, mode, dpm);
        repeat (40) @(negedge clk);
        for (int c = 0; c < 4 * RD * 2; c++) begin
            @(negedge clk);
            i = anode_idx(anode);
            total++;
            if (i < 0) begin
                bad++;
                $display("FAIL %s_anode: got %b want one-hot-low", name, anode);
            end else begin
                if (segments !== model_seg(v, mode, dpm, i) || dp !== ~dpm[i]) begin
                    bad++;
                    $display("FAIL %s_digit%0d: got seg=%b dp=%b want seg=%b dp=%b",
                             name, i, segments, dp, model_seg(v, mode, dpm, i), ~dpm[i]);
                end
                if (i != prev_i) begin
                    if (prev_i >= 0 && seen) begin
                        total++;
                        if (i != (prev_i + 1) % 4 || run != RD) begin
                            bad++;
                            $display("FAIL %s_scan: got idx %0d after %0d with dwell %0d want idx %0d dwell %0d",
                                     name, i, prev_i, run, (prev_i + 1) % 4, RD);
                        end
                    end
                    if (prev_i >= 0) seen = 1'b1;
                    prev_i = i;
                    run = 1;
                end else begin
                    run++;
                end
            end
        end
        total++;
        if (overflow !== (mode && v > 9999)) begin
            bad++;
            $display("FAIL %s_overflow: got %b want %b", name, overflow, (mode && v > 9999));
        end
    endtask

    task automatic test_busy_duty();
        int highs = 0;
        for (int c = 0; c < 36; c++) begin
            @(negedge clk);
            if (conv_busy) highs++;
        end
        total++;
        if (highs != 34) begin
            bad++;
            $display("FAIL busy_duty: got %0d busy cycles of 36 want 34", highs);
        end
    endtask

    task automatic test_overflow_clear();
        bit cleared = 1'b0;
        apply(7, 1'b1, 4'b0000);
        for (int c = 0; c < 40 && !cleared; c++) begin
            @(negedge clk);
            if (overflow === 1'b0) cleared = 1'b1;
        end
        total++;
        if (!cleared) begin
            bad++;
            $display("FAIL overflow_clear: got overflow=%b after 40 cycles want 0", overflow);
        end
    endtask

    // Change captured at LOAD appears exactly 18 cycles later, never partially
    task automatic test_latency();
        bit ok;
        int i;
        apply(12345, 1'b1, 4'b0000);
        repeat (40) @(negedge clk);
        wait_load(ok);
        if (ok) begin
            apply(16'h0001, 1'b0, 4'b0000);
            for (int k = 1; k <= 22; k++) begin
                @(negedge clk);
                total++;
                if (overflow !== (k < 18)) begin
                    bad++;
                    $display("FAIL latency_ovf_k%0d: got %b want %b", k, overflow, (k < 18));
                end
                i = anode_idx(anode);
                total++;
                if (i < 0) begin
                    bad++;
                    $display("FAIL latency_anode_k%0d: got %b", k, anode);
                end else if (k <= 18 && segments !== model_seg(12345, 1'b1, 4'b0000, i)) begin
                    bad++;
                    $display("FAIL latency_old_k%0d: got %b want %b", k, segments,
                             model_seg(12345, 1'b1, 4'b0000, i));
                end else if (k >= 19 && segments !== model_seg(1, 1'b0, 4'b0000, i)) begin
                    bad++;
                    $display("FAIL latency_new_k%0d: got %b want %b", k, segments,
                             model_seg(1, 1'b0, 4'b0000, i));
                end
            end
        end
    endtask

    // Reset during SHIFT aborts; restart commits 19 cycles after the reset edge
    task automatic test_reset_mid_shift();
        bit ok;
        int i;
        apply(12345, 1'b1, 4'b0000);
        wait_load(ok);
        if (ok) begin
            repeat (8) @(negedge clk);
            rst = 1'b1;
            apply(7, 1'b1, 4'b0000);
            @(negedge clk);
            rst = 1'b0;
            total++;
            if ({anode, segments, overflow, conv_busy} !== {4'b1111, 7'h7F, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL midreset_outputs: got anode=%b seg=%h ovf=%b busy=%b want 1111 7f 0 0",
                         anode, segments, overflow, conv_busy);
            end
            for (int k = 1; k <= 24; k++) begin
                @(negedge clk);
                total++;
                if (overflow !== 1'b0) begin
                    bad++;
                    $display("FAIL midreset_ovf_k%0d: got %b want 0", k, overflow);
                end
                i = anode_idx(anode);
                total++;
                if (i < 0) begin
                    bad++;
                    $display("FAIL midreset_anode_k%0d: got %b", k, anode);
                end else if (k <= 19 && segments !== model_seg(0, 1'b0, 4'b0000, i)) begin
                    bad++;
                    $display("FAIL midreset_old_k%0d: got %b want %b", k, segments,
                             model_seg(0, 1'b0, 4'b0000, i));
                end else if (k >= 20 && segments !== model_seg(7, 1'b1, 4'b0000, i)) begin
                    bad++;
                    $display("FAIL midreset_new_k%0d: got %b want %b", k, segments,
                             model_seg(7, 1'b1, 4'b0000, i));
                end
            end
        end
    endtask

    task automatic test_random();
        int v;
        bit mode;
        logic [3:0] dpm;
        for (int n = 0; n < 10; n++) begin
            mode = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: v = int'($urandom_range(0, 120));
                1: v = int'($urandom_range(0, 9999));
                default: v = int'($urandom_range(0, 65535));
            endcase
            dpm = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            test_display($sformatf("rand%0d", n), v, mode, dpm);
        end
    endtask

    initial begin
        test_reset();
        test_display("hex_abcd", 16'hABCD, 1'b0, 4'b0000);
        test_display("bcd_1234", 1234, 1'b1, 4'b0000);
        test_busy_duty();
        test_display("blank_45", 45, 1'b1, 4'b0000);
        test_display("dp_0045", 45, 1'b1, 4'b1000);
        test_display("bcd_0", 0, 1'b1, 4'b0000);
        test_display("ovf_12345", 12345, 1'b1, 4'b0000);
        test_overflow_clear();
        test_display("bcd_9999", 9999, 1'b1, 4'b0010);
        test_display("bcd_10000", 10000, 1'b1, 4'b0000);
        test_latency();
        test_reset_mid_shift();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
